// File: rtl/pe_array_feeder_pkg.sv
// Shared constants, base/state encodings and the zero-clamped score add
// used by the feeder and by the PE v_alpha logic.
package pe_array_feeder_pkg;

  localparam int V_E_F_BIT    = 16;
  localparam int ARRAY_LENGTH = 64;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One extra bit holds the sign of the sum; v <= max and minus_alpha <= 0
  // rule out positive overflow, so only the negative case needs clamping.
  function automatic logic [V_E_F_BIT-1:0] clamp_add(
    input logic [V_E_F_BIT-1:0] v,
    input logic [V_E_F_BIT-1:0] minus_alpha
  );
    logic [V_E_F_BIT:0] sum;
    sum = {v[V_E_F_BIT-1], v} + {minus_alpha[V_E_F_BIT-1], minus_alpha};
    return sum[V_E_F_BIT] ? '0 : sum[V_E_F_BIT-1:0];
  endfunction

endpackage

// File: rtl/pe_array_feeder.sv
// Drives PE[0] of the systolic Smith-Waterman array from the target-base
// stream and (on later passes) the saved boundary column, then flushes.
module pe_array_feeder
  import pe_array_feeder_pkg::*;
#(
  parameter int LEN_BIT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_BIT-1:0]   t_len,
  input  logic                 first_pass,
  input  logic [V_E_F_BIT-1:0] minus_alpha,
  input  logic                 base_valid,
  input  logic [1:0]           base_data,
  output logic                 base_ready,
  input  logic                 bnd_valid,
  input  logic [V_E_F_BIT-1:0] bnd_v,
  input  logic [V_E_F_BIT-1:0] bnd_f,
  output logic                 bnd_ready,
  output logic                 pe_enable,
  output logic                 pe_newline,
  output logic [1:0]           pe_t,
  output logic [V_E_F_BIT-1:0] pe_v,
  output logic [V_E_F_BIT-1:0] pe_v_alpha,
  output logic [V_E_F_BIT-1:0] pe_f,
  output logic                 busy,
  output logic                 done
);

  localparam int FLUSH_W = $clog2(ARRAY_LENGTH + 1);

  state_e               state_q, state_d;
  logic [LEN_BIT-1:0]   cnt_q, cnt_d;
  logic [LEN_BIT-1:0]   t_len_q, t_len_d;
  logic                 first_pass_q, first_pass_d;
  logic [V_E_F_BIT-1:0] minus_alpha_q, minus_alpha_d;
  logic                 first_q, first_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;

  logic                 pe_enable_q, pe_enable_d;
  logic                 pe_newline_q, pe_newline_d;
  logic [1:0]           pe_t_q, pe_t_d;
  logic [V_E_F_BIT-1:0] pe_v_q, pe_v_d;
  logic [V_E_F_BIT-1:0] pe_v_alpha_q, pe_v_alpha_d;
  logic [V_E_F_BIT-1:0] pe_f_q, pe_f_d;

  logic                 accept;
  logic [V_E_F_BIT-1:0] v_sel;
  logic [V_E_F_BIT-1:0] f_sel;

  // Each ready looks only at the other stream's valid, so both streams
  // advance in the same cycle without a combinational valid->ready loop.
  always_comb begin
    base_ready = 1'b0;
    bnd_ready  = 1'b0;
    if (state_q == ST_FEED) begin
      base_ready = first_pass_q | bnd_valid;
      bnd_ready  = ~first_pass_q & base_valid;
    end
  end

  assign accept = base_valid & base_ready;
  assign v_sel  = first_pass_q ? '0 : bnd_v;
  assign f_sel  = first_pass_q ? '0 : bnd_f;

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_len_d       = t_len_q;
    first_pass_d  = first_pass_q;
    minus_alpha_d = minus_alpha_q;
    first_d       = first_q;
    flush_d       = flush_q;
    pe_enable_d   = 1'b0;
    pe_newline_d  = 1'b0;
    pe_t_d        = pe_t_q;
    pe_v_d        = pe_v_q;
    pe_v_alpha_d  = pe_v_alpha_q;
    pe_f_d        = pe_f_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          t_len_d       = t_len;
          first_pass_d  = first_pass;
          minus_alpha_d = minus_alpha;
          cnt_d         = '0;
          first_d       = 1'b1;
          state_d       = (t_len == '0) ? ST_DONE : ST_FEED;
        end
      end

      ST_FEED: begin
        if (accept) begin
          pe_enable_d  = 1'b1;
          pe_newline_d = first_q;
          first_d      = 1'b0;
          pe_t_d       = base_data;
          pe_v_d       = v_sel;
          pe_f_d       = f_sel;
          pe_v_alpha_d = clamp_add(v_sel, minus_alpha_q);
          cnt_d        = cnt_q + LEN_BIT'(1);
          // Compare against t_len-1 so t_len = 2^LEN_BIT-1 never wraps.
          if (cnt_q == t_len_q - LEN_BIT'(1)) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end
        end
      end

      ST_FLUSH: begin
        pe_enable_d  = 1'b1;
        pe_t_d       = '0;
        pe_v_d       = '0;
        pe_v_alpha_d = '0;
        pe_f_d       = '0;
        flush_d      = flush_q + FLUSH_W'(1);
        if (flush_q == FLUSH_W'(ARRAY_LENGTH - 1)) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      t_len_q       <= '0;
      first_pass_q  <= 1'b0;
      minus_alpha_q <= '0;
      first_q       <= 1'b0;
      flush_q       <= '0;
      pe_enable_q   <= 1'b0;
      pe_newline_q  <= 1'b0;
      pe_t_q        <= '0;
      pe_v_q        <= '0;
      pe_v_alpha_q  <= '0;
      pe_f_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      t_len_q       <= t_len_d;
      first_pass_q  <= first_pass_d;
      minus_alpha_q <= minus_alpha_d;
      first_q       <= first_d;
      flush_q       <= flush_d;
      pe_enable_q   <= pe_enable_d;
      pe_newline_q  <= pe_newline_d;
      pe_t_q        <= pe_t_d;
      pe_v_q        <= pe_v_d;
      pe_v_alpha_q  <= pe_v_alpha_d;
      pe_f_q        <= pe_f_d;
    end
  end

  assign pe_enable  = pe_enable_q;
  assign pe_newline = pe_newline_q;
  assign pe_t       = pe_t_q;
  assign pe_v       = pe_v_q;
  assign pe_v_alpha = pe_v_alpha_q;
  assign pe_f       = pe_f_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder: directed steps plus random passes
// checked cycle by cycle against a pass-level behavioural model.
module tb_pe_array_feeder;

  localparam int FLUSH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] t_len = '0;
  logic        first_pass = 1'b0;
  logic [15:0] minus_alpha = '0;
  logic        base_valid = 1'b0;
  logic [1:0]  base_data = '0;
  logic        base_ready;
  logic        bnd_valid = 1'b0;
  logic [15:0] bnd_v = '0;
  logic [15:0] bnd_f = '0;
  logic        bnd_ready;
  logic        pe_enable, pe_newline, busy, done;
  logic [1:0]  pe_t;
  logic [15:0] pe_v, pe_v_alpha, pe_f;

  pe_array_feeder dut (
    .clk(clk), .rst(rst), .start(start), .t_len(t_len),
    .first_pass(first_pass), .minus_alpha(minus_alpha),
    .base_valid(base_valid), .base_data(base_data), .base_ready(base_ready),
    .bnd_valid(bnd_valid), .bnd_v(bnd_v), .bnd_f(bnd_f), .bnd_ready(bnd_ready),
    .pe_enable(pe_enable), .pe_newline(pe_newline), .pe_t(pe_t), .pe_v(pe_v),
    .pe_v_alpha(pe_v_alpha), .pe_f(pe_f), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_seen = 0;
  int done_seen = 0;

  // Model: elements still owed, flush cycles left, done pending, plus the
  // expected registered PE[0] outputs.
  int          m_left, m_flush, m_ma;
  bit          m_done, m_first, m_fp;
  logic        e_en, e_nl;
  logic [1:0]  e_t;
  logic [15:0] e_v, e_va, e_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_ref(input int v, input int ma);
    int s;
    s = v + ma;
    return (s < 0) ? 0 : s;
  endfunction

  function automatic bit model_busy();
    return (m_left > 0) || (m_flush > 0) || m_done;
  endfunction

  task automatic reset_model();
    m_left = 0; m_flush = 0; m_done = 0; m_first = 0; m_fp = 0; m_ma = 0;
    e_en = 0; e_nl = 0; e_t = '0; e_v = '0; e_va = '0; e_f = '0;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    bit exp_br, exp_nr, exp_busy, acc, idle_before, done_old;
    int fl_old;
    #1;
    exp_br   = (m_left > 0) && (m_fp || bnd_valid);
    exp_nr   = (m_left > 0) && !m_fp && base_valid;
    exp_busy = model_busy();
    chk("base_ready", base_ready, exp_br);
    chk("bnd_ready", bnd_ready, exp_nr);
    chk("busy", busy, exp_busy);
    chk("done", done, m_done);
    if (done === 1'b1) done_seen++;
    acc         = base_valid && exp_br;
    idle_before = !exp_busy;
    done_old    = m_done;
    fl_old      = m_flush;
    @(posedge clk);
    if (rst) begin
      reset_model();
    end else begin
      if (acc) begin
        e_en = 1; e_nl = m_first; m_first = 0; e_t = base_data;
        e_v  = m_fp ? 16'd0 : bnd_v;
        e_f  = m_fp ? 16'd0 : bnd_f;
        e_va = 16'(clamp_ref(int'($signed(e_v)), m_ma));
        m_left--;
        if (m_left == 0) m_flush = FLUSH;
      end else if (fl_old > 0) begin
        e_en = 1; e_nl = 0; e_t = '0; e_v = '0; e_va = '0; e_f = '0;
        m_flush--;
        if (m_flush == 0) m_done = 1;
      end else begin
        e_en = 0; e_nl = 0;
      end
      if (done_old) m_done = 0;
      if (idle_before && start) begin
        if (t_len == 0) m_done = 1;
        else begin
          m_left = int'(t_len); m_first = 1; m_fp = first_pass;
          m_ma = int'($signed(minus_alpha));
        end
      end
    end
    @(negedge clk);
    chk("pe_enable", pe_enable, e_en);
    chk("pe_newline", pe_newline, e_nl);
    chk("pe_t", pe_t, e_t);
    chk("pe_v", pe_v, e_v);
    chk("pe_v_alpha", pe_v_alpha, e_va);
    chk("pe_f", pe_f, e_f);
    if (pe_enable === 1'b1) en_seen++;
  endtask

  // Start pulse, then scramble config inputs to show they are not re-sampled.
  task automatic begin_pass(input int tlen, input bit fp, input int ma);
    en_seen = 0; done_seen = 0;
    start = 1; t_len = 12'(tlen); first_pass = fp; minus_alpha = 16'(ma);
    base_valid = 0; bnd_valid = 0;
    tick();
    start = 0; t_len = 12'($urandom); first_pass = ~fp; minus_alpha = 16'($urandom);
  endtask

  task automatic finish_pass(input int exp_en);
    int n;
    n = 0;
    base_valid = 0; bnd_valid = 0; start = 0;
    while (model_busy() && n < 10000) begin
      tick();
      n++;
    end
    chk("pass_timeout", n < 10000, 1);
    chk("enable_count", en_seen, exp_en);
    chk("done_count", done_seen, 1);
  endtask

  task automatic run_random(input int tlen, input bit fp, input int ma,
                            input int p_bv, input int p_nv);
    int n;
    begin_pass(tlen, fp, ma);
    n = 0;
    while (m_left > 0 && n < 20000) begin
      base_valid = ($urandom_range(99) < p_bv);
      base_data  = 2'($urandom);
      bnd_valid  = ($urandom_range(99) < p_nv);
      bnd_v      = 16'($urandom);
      bnd_f      = 16'($urandom);
      start      = ($urandom_range(9) == 0);
      tick();
      n++;
    end
    chk("feed_timeout", n < 20000, 1);
    finish_pass(tlen + FLUSH);
  endtask

  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    rst = 1; tick(); tick();
    rst = 0;

    // First pass, A C G T with base_valid held high
    begin_pass(4, 1, -11);
    base_valid = 1;
    for (int i = 0; i < 4; i++) begin
      base_data = 2'(i);
      tick();
      if (i == 0) chk("acgt_newline", pe_newline, 1);
    end
    finish_pass(4 + FLUSH);

    // Reset in the middle of FEED, then a clean short pass
    begin_pass(8, 1, -5);
    base_valid = 1;
    repeat (3) tick();
    rst = 1; base_valid = 0;
    tick();
    rst = 0;
    tick(); tick();
    chk("no_done_after_reset", done_seen, 0);
    chk("idle_enable_after_reset", pe_enable, 0);
    begin_pass(2, 1, -5);
    base_valid = 1; base_data = 2'd3;
    tick(); tick();
    finish_pass(2 + FLUSH);

    // Boundary stream with clamp, and a two-cycle bnd_valid stall
    begin_pass(2, 0, -11);
    base_valid = 1; base_data = 2'd2; bnd_valid = 1; bnd_v = 16'd20; bnd_f = 16'd5;
    tick();
    chk("va_20_minus_11", pe_v_alpha, 16'd9);
    bnd_valid = 0; base_data = 2'd1; bnd_v = 16'd99;
    tick(); tick();
    chk("stall_hold_v", pe_v, 16'd20);
    bnd_valid = 1; base_data = 2'd3; bnd_v = 16'd3; bnd_f = 16'hFFFE;
    tick();
    chk("va_3_clamped", pe_v_alpha, 16'd0);
    finish_pass(2 + FLUSH);

    // Bubbles on base_valid
    begin_pass(2, 1, -3);
    base_valid = 1; base_data = 2'd1; tick();
    base_valid = 0; tick();
    base_valid = 1; base_data = 2'd2; tick();
    base_valid = 0; tick();
    finish_pass(2 + FLUSH);

    // Empty pass
    begin_pass(0, 1, -3);
    finish_pass(0);

    // Start during FLUSH is ignored
    begin_pass(1, 1, 0);
    base_valid = 1; tick();
    base_valid = 0; repeat (5) tick();
    start = 1; t_len = 12'd5; tick();
    start = 0;
    finish_pass(1 + FLUSH);

    // Arithmetic extremes
    begin_pass(1, 0, -1);
    base_valid = 1; bnd_valid = 1; bnd_v = 16'h7FFF; bnd_f = 16'h1234;
    tick();
    chk("va_max", pe_v_alpha, 16'h7FFE);
    finish_pass(1 + FLUSH);
    begin_pass(1, 0, -32768);
    base_valid = 1; bnd_valid = 1; bnd_v = 16'd0;
    tick();
    chk("va_min_alpha", pe_v_alpha, 16'd0);
    finish_pass(1 + FLUSH);

    // Random passes, then the longest legal pass
    for (int k = 0; k < 6; k++)
      run_random(int'($urandom_range(40, 1)), bit'($urandom_range(1)),
                 -int'($urandom_range(32768)), 70, 70);
    run_random(4095, 1, -7, 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Transmit end of the PE chain protocol: drives the PE[0] inputs of the systolic Smith-Waterman array (newline, t, v, v_alpha, f, enable) from a target-base stream.
- Also consumes a boundary-column stream saved from the previous pass for queries longer than the array.
- Sits between target memory / boundary FIFO and the PE array, and controls the array enable so stalls freeze the whole chain.

Parameters:
- V_E_F_BIT, 16, score width (v, f, alpha; two's complement).
- LEN_BIT, 12, target-length counter width.
- ARRAY_LENGTH, 64, PE count; number of flush cycles after the last element.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, begins a pass; ignored unless IDLE.
- t_len  in  LEN_BIT  number of target bases this pass; sampled on start.
- first_pass  in  1  1 = boundary is constant zero; 0 = boundary from bnd stream; sampled on start.
- minus_alpha  in  V_E_F_BIT  gap-open penalty, negative value; sampled on start.
- base_valid  in  1  target base available.
- base_data  in  2  base code.
- base_ready  out  1  base accepted when valid and ready.
- bnd_valid  in  1  boundary pair available.
- bnd_v  in  V_E_F_BIT  previous-pass v.
- bnd_f  in  V_E_F_BIT  previous-pass f.
- bnd_ready  out  1  boundary accepted when valid and ready.
- pe_enable  out  1  array advance strobe.
- pe_newline  out  1  first element of a pass.
- pe_t  out  2  base to PE[0].
- pe_v  out  V_E_F_BIT  boundary v.
- pe_v_alpha  out  V_E_F_BIT  max(v + minus_alpha, 0).
- pe_f  out  V_E_F_BIT  boundary f.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: state IDLE. All outputs 0; counters, sampled config and first-flag cleared. Reset mid-pass aborts immediately with no done pulse.
- States and transitions:
  - IDLE -> FEED on start with t_len != 0.
  - IDLE -> DONE on start with t_len == 0; no element emitted, no newline.
  - FEED -> FLUSH on the cycle the t_len-th element is accepted.
  - FLUSH -> DONE after ARRAY_LENGTH cycles.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Handshake:
  - In FEED with first_pass=1: base_ready=1, bnd_ready=0.
  - In FEED with first_pass=0: base_ready=bnd_valid and bnd_ready=base_valid; both streams are consumed together in one cycle.
  - ready=0 outside FEED.
  - ready depends on the other stream's valid, never on its own valid.
- Output timing: registered, 1-cycle latency. The cycle after an accept:
  - pe_enable=1 and pe_t=base_data.
  - pe_v/pe_f = bnd_v/bnd_f, or 0/0 if first_pass.
  - pe_newline=1 only for the first accepted element of the pass.
- Stall: in FEED, any cycle with no accept gives pe_enable=0 the next cycle. Data outputs hold their last values and pe_newline=0.
- FLUSH: pe_enable=1 every cycle with t=0, v=0, v_alpha=0, f=0, newline=0 so the last real element drains to PE[ARRAY_LENGTH].
- v_alpha arithmetic: sum computed at V_E_F_BIT+1 bits; if negative, output 0; else take the low V_E_F_BIT bits. Positive overflow is impossible because v is at most the max positive value and minus_alpha is at most 0.
- Counter: counts accepts, compared against the sampled t_len. t_len = 2^LEN_BIT-1 must work without wrap.
- Config changes on t_len / first_pass / minus_alpha mid-pass have no effect.
- Back-to-back passes: start during DONE is ignored; start is accepted from the IDLE cycle that follows DONE.

Decomposition:
- Shared package: V_E_F_BIT, ARRAY_LENGTH, 2-bit base codes (A=0, C=1, G=2, T=3), FSM state encoding (IDLE, FEED, FLUSH, DONE).
- No sub-module required. The zero-clamped add is a function in the package, shared with the PE's v_alpha logic.

Test Plan:
- Reset mid-FEED (after 3 accepts of t_len=8) -> next cycle: outputs all 0, busy=0, ready=0, no done; a new start with t_len=2 then runs cleanly.
- first_pass=1, t_len=4, bases A,C,G,T with base_valid held high, minus_alpha=-11 -> pe_enable high 4 cycles starting 1 cycle after the first accept; newline only on the first; t=0,1,2,3; v=f=v_alpha=0; then 64 flush cycles; done pulses exactly once.
- first_pass=0, bnd pairs (v=20,f=5), (v=3,f=-2), minus_alpha=-11 -> v_alpha = 9 then 0 (clamped). bnd_valid withheld 2 cycles -> base_ready=0 and pe_enable=0 for those cycles with outputs held.
- Bubbles: base_valid toggling 1,0,1,0 for t_len=2 -> exactly 2 enable pulses with a gap, newline only on the first, FLUSH entered after the 2nd accept.
- t_len=0 start -> done 1 cycle later, pe_enable never asserted. A start asserted during FLUSH is ignored (pass length unchanged).
- Max positive bnd_v=32767, minus_alpha=-1 -> v_alpha=32766. minus_alpha=-32768 with bnd_v=0 -> v_alpha=0.
